// File: rtl/fetch_queue_pkg.sv
// Shared types and defaults for the instruction fetch queue.
// The default geometry is a 4-entry queue fed by a 512-byte instruction ROM.
package fetch_queue_pkg;

    localparam int unsigned FQ_DEPTH  = 4;
    localparam int unsigned FQ_ROM_AW = 9;

    localparam logic [31:0] NOP_INSTR = 32'h0000_0000;

    typedef struct packed {
        logic [31:0] pc;
        logic [31:0] instr;
    } fq_entry_t;

    // Instruction addresses are always word aligned.
    function automatic logic [31:0] fq_align_pc(input logic [31:0] pc);
        return pc & ~32'h0000_0003;
    endfunction

endpackage

// File: rtl/fetch_queue_storage.sv
// Entry array for the fetch queue: one write port, one combinational read port.
// Contents are deliberately not reset; validity is tracked by the owner.
module fetch_queue_storage
    import fetch_queue_pkg::*;
#(
    parameter int unsigned DEPTH = FQ_DEPTH,
    parameter int unsigned PW    = $clog2(DEPTH)
) (
    input  logic            clk,
    input  logic            i_we,
    input  logic [PW-1:0]   i_waddr,
    input  fq_entry_t       i_wdata,
    input  logic [PW-1:0]   i_raddr,
    output fq_entry_t       o_rdata
);

    fq_entry_t r_mem [DEPTH];

    always_ff @(posedge clk) begin
        if (i_we) begin
            r_mem[i_waddr] <= i_wdata;
        end
    end

    assign o_rdata = r_mem[i_raddr];

endmodule

// File: rtl/fetch_queue.sv
// Instruction fetch queue: walks a fetch pointer through a combinational ROM,
// buffers {pc, instr} pairs and presents the head entry to the decode stage.
module fetch_queue
    import fetch_queue_pkg::*;
#(
    parameter int unsigned DEPTH  = FQ_DEPTH,
    parameter int unsigned ROM_AW = FQ_ROM_AW
) (
    input  logic                     clk,
    input  logic                     reset,
    output logic [ROM_AW-1:0]        rom_addr,
    input  logic [31:0]              rom_data,
    input  logic                     deq,
    input  logic                     redirect,
    input  logic [31:0]              redirect_pc,
    output logic                     out_valid,
    output logic [31:0]              out_instr,
    output logic [31:0]              out_pc,
    output logic [31:0]              out_pc_plus4,
    output logic [$clog2(DEPTH):0]   count
);

    localparam int unsigned PW = $clog2(DEPTH);
    localparam int unsigned CW = PW + 1;

    logic [PW-1:0] r_head;
    logic [PW-1:0] r_tail;
    logic [CW-1:0] r_count;
    logic [31:0]   r_fpc;

    logic [PW-1:0] w_head_nxt;
    logic [PW-1:0] w_tail_nxt;
    logic [CW-1:0] w_count_nxt;
    logic [31:0]   w_fpc_nxt;

    logic          w_full;
    logic          w_valid;
    logic          w_pop;
    logic          w_push;
    fq_entry_t     w_wr_entry;
    fq_entry_t     w_head_entry;

    assign w_full  = (r_count == CW'(DEPTH));
    // Gating with reset keeps the outputs quiet the instant reset rises.
    assign w_valid = (r_count != '0) && !reset;
    assign w_pop   = deq && w_valid && !redirect;
    assign w_push  = !redirect && (!w_full || w_pop);

    assign w_wr_entry.pc    = r_fpc;
    assign w_wr_entry.instr = rom_data;

    fetch_queue_storage #(
        .DEPTH (DEPTH),
        .PW    (PW)
    ) u_storage (
        .clk     (clk),
        .i_we    (w_push),
        .i_waddr (r_tail),
        .i_wdata (w_wr_entry),
        .i_raddr (r_head),
        .o_rdata (w_head_entry)
    );

    always_comb begin
        w_head_nxt  = r_head;
        w_tail_nxt  = r_tail;
        w_count_nxt = r_count;
        w_fpc_nxt   = r_fpc;
        if (redirect) begin
            w_head_nxt  = '0;
            w_tail_nxt  = '0;
            w_count_nxt = '0;
            w_fpc_nxt   = fq_align_pc(redirect_pc);
        end else begin
            if (w_pop) begin
                w_head_nxt = r_head + PW'(1);
            end
            if (w_push) begin
                w_tail_nxt = r_tail + PW'(1);
                w_fpc_nxt  = r_fpc + 32'd4;
            end
            unique case ({w_push, w_pop})
                2'b10:   w_count_nxt = r_count + CW'(1);
                2'b01:   w_count_nxt = r_count - CW'(1);
                default: w_count_nxt = r_count;
            endcase
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_head  <= '0;
            r_tail  <= '0;
            r_count <= '0;
            r_fpc   <= '0;
        end else begin
            r_head  <= w_head_nxt;
            r_tail  <= w_tail_nxt;
            r_count <= w_count_nxt;
            r_fpc   <= w_fpc_nxt;
        end
    end

    always_comb begin
        out_valid    = w_valid;
        out_instr    = NOP_INSTR;
        out_pc       = '0;
        out_pc_plus4 = '0;
        if (w_valid) begin
            out_instr    = w_head_entry.instr;
            out_pc       = w_head_entry.pc;
            out_pc_plus4 = w_head_entry.pc + 32'd4;
        end
    end

    assign count    = reset ? '0 : r_count;
    assign rom_addr = r_fpc[ROM_AW-1:0];

endmodule

// File: tb/tb_fetch_queue.sv
// Bench for fetch_queue: directed vectors with literal checks, plus a queue-based
// model compared against the DUT on every falling clock edge.
module tb_fetch_queue;

    localparam int unsigned DEPTH  = 4;
    localparam int unsigned ROM_AW = 9;
    localparam int unsigned CW     = $clog2(DEPTH) + 1;

    typedef struct packed {
        logic [31:0] pc;
        logic [31:0] instr;
    } ent_t;

    logic              clk = 1'b0;
    logic              reset = 1'b1;
    logic              deq = 1'b0;
    logic              redirect = 1'b0;
    logic [31:0]       redirect_pc = '0;
    logic [ROM_AW-1:0] rom_addr;
    logic [31:0]       rom_data;
    logic              out_valid;
    logic [31:0]       out_instr;
    logic [31:0]       out_pc;
    logic [31:0]       out_pc_plus4;
    logic [CW-1:0]     count;

    int total = 0;
    int bad   = 0;

    always #5 clk = ~clk;

    function automatic logic [31:0] rom_word(input logic [ROM_AW-1:0] a);
        return 32'h100 + 32'(a >> 2);
    endfunction

    assign rom_data = rom_word(rom_addr);

    fetch_queue #(
        .DEPTH  (DEPTH),
        .ROM_AW (ROM_AW)
    ) dut (
        .clk          (clk),
        .reset        (reset),
        .rom_addr     (rom_addr),
        .rom_data     (rom_data),
        .deq          (deq),
        .redirect     (redirect),
        .redirect_pc  (redirect_pc),
        .out_valid    (out_valid),
        .out_instr    (out_instr),
        .out_pc       (out_pc),
        .out_pc_plus4 (out_pc_plus4),
        .count        (count)
    );

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %h want %h at %0t", name, act, exp, $time);
        end
    endtask

    // Model: a queue of {pc, instr}; each clock pops the head on deq, then refills if room.
    ent_t        mq[$];
    logic [31:0] m_fpc = '0;

    initial begin
        forever begin
            @(posedge clk or posedge reset);
            if (reset) begin
                mq.delete();
                m_fpc = '0;
            end else if (redirect) begin
                mq.delete();
                m_fpc = redirect_pc & ~32'h3;
            end else begin
                if (deq && mq.size() > 0) void'(mq.pop_front());
                if (mq.size() < DEPTH) begin
                    mq.push_back('{pc: m_fpc, instr: rom_word(m_fpc[ROM_AW-1:0])});
                    m_fpc = m_fpc + 32'd4;
                end
            end
        end
    end

    always @(negedge clk) begin : cmp
        ent_t h;
        h = (mq.size() > 0) ? mq[0] : '0;
        check("m_count", 32'(count), 32'(mq.size()));
        check("m_valid", 32'(out_valid), 32'(mq.size() > 0));
        check("m_instr", out_instr, h.instr);
        check("m_pc", out_pc, h.pc);
        check("m_pc_plus4", out_pc_plus4, (mq.size() > 0) ? h.pc + 32'd4 : 32'h0);
        check("m_rom_addr", 32'(rom_addr), 32'(m_fpc[ROM_AW-1:0]));
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    logic [31:0] pat;

    initial begin
        reset = 1'b1;
        repeat (2) @(posedge clk);
        #1;
        reset = 1'b0;

        // Fill from reset with no consumer.
        for (int i = 0; i < 6; i++) begin
            tick();
            check("fill_count", 32'(count), (i < 4) ? 32'(i + 1) : 32'd4);
        end
        check("fill_pc", out_pc, 32'h0);
        check("fill_instr", out_instr, 32'h100);
        check("fill_rom_addr", 32'(rom_addr), 32'd16);

        // Streaming at full: one pop and one push per cycle.
        deq = 1'b1;
        for (int k = 1; k <= 8; k++) begin
            tick();
            check("stream_count", 32'(count), 32'd4);
            check("stream_pc", out_pc, 32'(4 * k));
            check("stream_instr", out_instr, 32'(32'h100 + k));
        end
        deq = 1'b0;

        // Bring count to 3, then redirect with deq held.
        redirect = 1'b1;
        redirect_pc = 32'h0;
        tick();
        redirect = 1'b0;
        repeat (3) tick();
        check("pre_redir_count", 32'(count), 32'd3);
        redirect = 1'b1;
        redirect_pc = 32'h0000_0042;
        deq = 1'b1;
        tick();
        check("redir_count", 32'(count), 32'd0);
        check("redir_valid", 32'(out_valid), 32'd0);
        check("redir_instr", out_instr, 32'h0);
        check("redir_pc", out_pc, 32'h0);
        redirect = 1'b0;
        tick();
        check("post_redir_count", 32'(count), 32'd1);
        check("post_redir_pc", out_pc, 32'h40);
        check("post_redir_pc4", out_pc_plus4, 32'h44);
        check("post_redir_instr", out_instr, 32'h110);
        tick();
        check("one_pushpop_count", 32'(count), 32'd1);
        check("one_pushpop_pc", out_pc, 32'h44);
        deq = 1'b0;

        // Fetch pointer wrap at the top of the address space.
        redirect = 1'b1;
        redirect_pc = 32'hFFFF_FFF8;
        tick();
        check("wrap_rom0", 32'(rom_addr), 32'h1F8);
        redirect = 1'b0;
        tick();
        check("wrap_rom1", 32'(rom_addr), 32'h1FC);
        check("wrap_head_pc", out_pc, 32'hFFFF_FFF8);
        tick();
        check("wrap_rom2", 32'(rom_addr), 32'h000);
        tick();
        check("wrap_rom3", 32'(rom_addr), 32'h004);
        deq = 1'b1;
        tick();
        check("wrap_pc_fffc", out_pc, 32'hFFFF_FFFC);
        check("wrap_pc4_zero", out_pc_plus4, 32'h0);
        tick();
        check("wrap_pc_zero", out_pc, 32'h0);
        check("wrap_instr_zero", out_instr, 32'h100);
        deq = 1'b0;

        // Mixed consumer pattern with one mid-stream redirect.
        pat = 32'hB5C3_9A61;
        for (int i = 0; i < 32; i++) begin
            deq = pat[i];
            redirect = (i == 13);
            redirect_pc = 32'h0000_0107;
            tick();
        end
        redirect = 1'b0;
        deq = 1'b0;

        // Asynchronous reset between edges at count 3.
        redirect = 1'b1;
        redirect_pc = 32'h0000_0200;
        tick();
        redirect = 1'b0;
        repeat (3) tick();
        check("pre_reset_count", 32'(count), 32'd3);
        #2;
        reset = 1'b1;
        #1;
        check("arst_count", 32'(count), 32'd0);
        check("arst_valid", 32'(out_valid), 32'd0);
        check("arst_instr", out_instr, 32'h0);
        check("arst_pc", out_pc, 32'h0);
        check("arst_pc4", out_pc_plus4, 32'h0);
        check("arst_rom_addr", 32'(rom_addr), 32'h0);
        deq = 1'b1;
        redirect = 1'b1;
        redirect_pc = 32'h0000_0080;
        repeat (2) tick();
        check("held_reset_count", 32'(count), 32'd0);
        reset = 1'b0;
        redirect = 1'b0;
        deq = 1'b0;
        tick();
        check("rel_count", 32'(count), 32'd1);
        check("rel_pc", out_pc, 32'h0);
        check("rel_instr", out_instr, 32'h100);
        tick();
        check("rel_count2", 32'(count), 32'd2);

        @(negedge clk);
        #1;
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule

// File: doc/fetch_queue.md
FETCH_QUEUE -- requirements
Module: fetch_queue

Interface
REQ-001 Parameter DEPTH, default 4, number of queue entries; power of two, 2..16.
REQ-002 Parameter ROM_AW, default 9, instruction ROM byte-address width.
REQ-003 clk  input  1  single clock; all state updates on rising edge.
REQ-004 reset  input  1  asynchronous, active-high reset.
REQ-005 rom_addr  output  ROM_AW  byte address to combinational instruction ROM, equal to fpc[ROM_AW-1:0].
REQ-006 rom_data  input  32  instruction returned by ROM for rom_addr, same cycle.
REQ-007 deq  input  1  consumer (IF/ID load enable) accepts the head entry this cycle.
REQ-008 redirect  input  1  taken branch/jump; flush the queue and refetch.
REQ-009 redirect_pc  input  32  target address for redirect.
REQ-010 out_valid  output  1  head entry present.
REQ-011 out_instr  output  32  head instruction; 32'h0000_0000 when out_valid=0.
REQ-012 out_pc  output  32  address of the head instruction; 0 when out_valid=0.
REQ-013 out_pc_plus4  output  32  out_pc+4, modulo 2^32; 0 when out_valid=0.
REQ-014 count  output  $clog2(DEPTH)+1  number of occupied entries.

Function
REQ-015 Internal fetch pointer fpc (32 bits); head/tail pointers of $clog2(DEPTH) bits wrap modulo DEPTH.
REQ-016 Push condition: redirect=0 and (count<DEPTH or pop this cycle); push writes {fpc, rom_data} at tail, tail+1, fpc+4.
REQ-017 Pop condition: deq=1, out_valid=1, redirect=0; pop advances head by 1.
REQ-018 Push and pop in the same cycle leave count unchanged, including at full and at count=1.
REQ-019 deq while empty is ignored: no pointer or count change.
REQ-020 Outputs out_valid/out_instr/out_pc/out_pc_plus4 are combinational from head entry and count; no added latency.
REQ-021 Latency: an instruction fetched at cycle N is visible at out_* from cycle N+1.
REQ-022 Redirect, highest priority after reset: count<=0, head<=tail<=0, fpc<=redirect_pc with bits [1:0] forced 0; no push, no pop that cycle.
REQ-023 First entry after redirect appears one cycle after redirect, holding pc=redirect_pc&~3.
REQ-024 fpc wraps 32'hFFFF_FFFC -> 0; rom_addr wraps at 2^ROM_AW naturally by truncation.
REQ-025 count never exceeds DEPTH and never underflows, under any input sequence.

Reset
REQ-026 Reset asserted, at any time, immediately forces fpc=0, head=tail=0, count=0, out_valid=0, out_instr=0, out_pc=0, out_pc_plus4=0.
REQ-027 Reset asserted mid-operation discards all entries; redirect and deq are ignored while reset=1.
REQ-028 The first push after reset release occurs on the first rising edge with reset=0 and writes pc=0.

Structure
REQ-029 Shared package fetch_queue_pkg holds NOP_INSTR=32'h0000_0000, default DEPTH, ROM_AW, and the entry record type {pc[31:0], instr[31:0]}.
REQ-030 One sub-module fetch_queue_storage: DEPTH x 64-bit register array, one write port, one combinational read port, no reset on array contents.
REQ-031 Pointer, count and fpc logic reside in fetch_queue; storage holds no control state.

Verification
REQ-032 Reset, ROM word i = 32'h100+i, deq=0 for 6 cycles -> count 1,2,3,4,4,4; out_pc=0, out_instr=32'h100; rom_addr holds at 16.
REQ-033 Full queue, deq=1 continuously -> count stays 4, out_pc increments 0,4,8,... once per cycle, no entry skipped or duplicated.
REQ-034 count=3, redirect=1 with redirect_pc=32'h0000_0042, deq=1 -> next cycle count=1, out_pc=32'h40, out_pc_plus4=32'h44, no pop.
REQ-035 Empty queue (redirect held 1 for one cycle then deq=1 same cycle) -> out_valid=0, out_instr=0, count stays 0, then 1.
REQ-036 redirect_pc=32'hFFFF_FFF8, deq=0 -> entries at pc FFFF_FFF8, FFFF_FFFC, 0, 4; rom_addr 0x1F8, 0x1FC, 0x000, 0x004.
REQ-037 Reset asserted between clock edges at count=3 -> outputs zero immediately, before next edge; after release out_pc=0 sequence restarts.
